// File: rtl/riscv_core_csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, trap causes,
// CSR op encodings and mstatus bit positions.
package riscv_core_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // Interrupt codes double as the mie/mip bit positions.
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam logic [63:0] CAUSE_MSI     = 64'h8000_0000_0000_0003;
  localparam logic [63:0] CAUSE_MTI     = 64'h8000_0000_0000_0007;
  localparam logic [63:0] CAUSE_MEI     = 64'h8000_0000_0000_000B;
  localparam logic [63:0] CAUSE_ILLEGAL = 64'd2;
  localparam logic [63:0] CAUSE_BREAK   = 64'd3;
  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_op_e;

endpackage

// File: rtl/riscv_core_csr_counter.sv
// Free-running counter with an increment enable and a direct load that
// takes precedence over the increment.
module riscv_core_csr_counter #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_we,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_we)       cnt_d = i_wdata;
    else if (i_inc) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_count = cnt_q;

endmodule

// File: rtl/riscv_core_csr_file.sv
// M-mode CSR file and trap sequencer. mcycle/minstret exist only when
// RISCV_CSR_COUNTERS_EN is defined; otherwise they read 0 and ignore writes.
module riscv_core_csr_file
  import riscv_core_csr_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] HART_ID  = '0,
  parameter logic [XLEN-1:0] MISA_VAL = 64'h8000_0000_0014_1105
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_csr_valid,
  input  logic            i_csr_ecall,
  input  logic            i_csr_ebreak,
  input  logic            i_csr_mret,
  input  logic            i_csr_wen,
  input  logic            i_csr_illegal,
  input  logic [2:0]      i_csr_funct3,
  input  logic [11:0]     i_csr_addr,
  input  logic [4:0]      i_csr_rs1_idx,
  input  logic [XLEN-1:0] i_csr_rs1_data,
  input  logic [XLEN-1:0] i_csr_pc,
  input  logic [XLEN-1:0] i_csr_tval,
  input  logic            i_csr_retire,
  input  logic            i_csr_irq_ext,
  input  logic            i_csr_irq_timer,
  input  logic            i_csr_irq_soft,
  output logic [XLEN-1:0] o_csr_rdata,
  output logic            o_csr_illegal,
  output logic            o_csr_trap,
  output logic            o_csr_redirect,
  output logic [XLEN-1:0] o_csr_redirect_pc
);

  logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic            meie_q, meie_d, mtie_q, mtie_d, msie_q, msie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mcycle, minstret;

  logic            csr_op, wr_attempt, addr_ok, addr_ro, csr_ill, wr_en;
  logic [XLEN-1:0] old_val, src, new_val;
  logic            p_e, p_t, p_s, ill, ebreak_v, ecall_v, trap, mret_take, is_irq;
  logic [3:0]      irq_code;
  logic [XLEN-1:0] cause, tval_sel, tvec_base, trap_pc;

  assign csr_op     = i_csr_valid & i_csr_wen & (i_csr_funct3 != CSR_NONE);
  // RS/RC with a zero source register/immediate is a pure read.
  assign wr_attempt = csr_op & ((i_csr_funct3[1:0] == 2'b01) | (i_csr_rs1_idx != 5'd0));
  assign src        = i_csr_funct3[2] ? {{(XLEN-5){1'b0}}, i_csr_rs1_idx} : i_csr_rs1_data;

  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    addr_ro = 1'b0;
    case (i_csr_addr)
      CSR_MSTATUS: begin
        old_val[MST_MIE]               = mst_mie_q;
        old_val[MST_MPIE]              = mst_mpie_q;
        old_val[MST_MPP_HI:MST_MPP_LO] = 2'b11;
      end
      CSR_MISA:    begin old_val = MISA_VAL; addr_ro = 1'b1; end
      CSR_MHARTID: begin old_val = HART_ID;  addr_ro = 1'b1; end
      CSR_MIE: begin
        old_val[IRQ_MEI] = meie_q;
        old_val[IRQ_MTI] = mtie_q;
        old_val[IRQ_MSI] = msie_q;
      end
      CSR_MIP: begin
        old_val[IRQ_MEI] = i_csr_irq_ext;
        old_val[IRQ_MTI] = i_csr_irq_timer;
        old_val[IRQ_MSI] = i_csr_irq_soft;
        addr_ro          = 1'b1;
      end
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MTVAL:    old_val = mtval_q;
      CSR_MCYCLE:   old_val = mcycle;
      CSR_MINSTRET: old_val = minstret;
      default:      addr_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (i_csr_funct3[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  assign csr_ill  = csr_op & (~addr_ok | (addr_ro & wr_attempt));
  assign p_e      = i_csr_valid & mst_mie_q & meie_q & i_csr_irq_ext;
  assign p_s      = i_csr_valid & mst_mie_q & msie_q & i_csr_irq_soft;
  assign p_t      = i_csr_valid & mst_mie_q & mtie_q & i_csr_irq_timer;
  assign ill      = i_csr_valid & (i_csr_illegal | csr_ill);
  assign ebreak_v = i_csr_valid & i_csr_ebreak;
  assign ecall_v  = i_csr_valid & i_csr_ecall;
  assign trap      = p_e | p_s | p_t | ill | ebreak_v | ecall_v;
  assign mret_take = i_csr_valid & i_csr_mret & ~trap;
  assign wr_en     = wr_attempt & ~trap & ~mret_take;

  always_comb begin
    cause    = CAUSE_ECALL_M;
    irq_code = '0;
    is_irq   = 1'b0;
    tval_sel = '0;
    if (p_e)           begin cause = CAUSE_MEI; irq_code = IRQ_MEI; is_irq = 1'b1; end
    else if (p_s)      begin cause = CAUSE_MSI; irq_code = IRQ_MSI; is_irq = 1'b1; end
    else if (p_t)      begin cause = CAUSE_MTI; irq_code = IRQ_MTI; is_irq = 1'b1; end
    else if (ill)      begin cause = CAUSE_ILLEGAL; tval_sel = i_csr_tval; end
    else if (ebreak_v) begin cause = CAUSE_BREAK;   tval_sel = i_csr_pc;   end
  end

  // Only interrupts are vectored; exceptions always land on the base.
  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign trap_pc   = (mtvec_q[0] & is_irq) ?
                     tvec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00} : tvec_base;

  always_comb begin
    mst_mie_d  = mst_mie_q;  mst_mpie_d = mst_mpie_q;
    meie_d     = meie_q;     mtie_d     = mtie_q;     msie_d = msie_q;
    mtvec_d    = mtvec_q;    mscratch_d = mscratch_q; mepc_d = mepc_q;
    mcause_d   = mcause_q;   mtval_d    = mtval_q;
    if (trap) begin
      mepc_d     = i_csr_pc & ~{{(XLEN-1){1'b0}}, 1'b1};
      mcause_d   = cause;
      mtval_d    = tval_sel;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_take) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (wr_en) begin
      case (i_csr_addr)
        CSR_MSTATUS: begin mst_mie_d = new_val[MST_MIE]; mst_mpie_d = new_val[MST_MPIE]; end
        CSR_MIE: begin
          meie_d = new_val[IRQ_MEI]; mtie_d = new_val[IRQ_MTI]; msie_d = new_val[IRQ_MSI];
        end
        CSR_MTVEC:    mtvec_d    = new_val[1] ? {new_val[XLEN-1:2], 2'b00} : new_val;
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = new_val & ~{{(XLEN-1){1'b0}}, 1'b1};
        CSR_MCAUSE:   mcause_d   = new_val;
        CSR_MTVAL:    mtval_d    = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mst_mie_q <= 1'b0; mst_mpie_q <= 1'b0;
      meie_q    <= 1'b0; mtie_q     <= 1'b0; msie_q <= 1'b0;
      mtvec_q   <= '0;   mscratch_q <= '0;   mepc_q <= '0;
      mcause_q  <= '0;   mtval_q    <= '0;
    end else begin
      mst_mie_q <= mst_mie_d; mst_mpie_q <= mst_mpie_d;
      meie_q    <= meie_d;    mtie_q     <= mtie_d;     msie_q <= msie_d;
      mtvec_q   <= mtvec_d;   mscratch_q <= mscratch_d; mepc_q <= mepc_d;
      mcause_q  <= mcause_d;  mtval_q    <= mtval_d;
    end
  end

`ifdef RISCV_CSR_COUNTERS_EN
  riscv_core_csr_counter #(.W(XLEN)) u_mcycle (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (1'b1),
    .i_we    (wr_en & (i_csr_addr == CSR_MCYCLE)),
    .i_wdata (new_val),
    .o_count (mcycle)
  );
  riscv_core_csr_counter #(.W(XLEN)) u_minstret (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (i_csr_valid & i_csr_retire & ~trap),
    .i_we    (wr_en & (i_csr_addr == CSR_MINSTRET)),
    .i_wdata (new_val),
    .o_count (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = i_csr_retire;
  assign mcycle        = '0;
  assign minstret      = '0;
`endif

  assign o_csr_rdata       = i_rst ? '0 : old_val;
  assign o_csr_illegal     = ~i_rst & csr_ill;
  assign o_csr_trap        = ~i_rst & trap;
  assign o_csr_redirect    = ~i_rst & (trap | mret_take);
  assign o_csr_redirect_pc = i_rst ? '0 : trap ? trap_pc : mret_take ? mepc_q : '0;

endmodule

// File: tb/tb_riscv_core_csr_file.sv
// Directed bench for riscv_core_csr_file: CSR ops, trap entry/priority, mret
// and counter behaviour (counters checked against 0 when the feature is off).
module tb_riscv_core_csr_file;

`ifdef RISCV_CSR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        valid, ecall, ebreak, mret, wen, illegal, retire, irq_e, irq_t, irq_s;
  logic [2:0]  f3;
  logic [11:0] addr;
  logic [4:0]  idx;
  logic [63:0] rs1, pc, tval;
  logic [63:0] rdata, rpc;
  logic        ill_o, trap_o, redir_o;
  logic [63:0] v;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  riscv_core_csr_file dut (
    .i_clk(clk), .i_rst(rst), .i_csr_valid(valid), .i_csr_ecall(ecall),
    .i_csr_ebreak(ebreak), .i_csr_mret(mret), .i_csr_wen(wen),
    .i_csr_illegal(illegal), .i_csr_funct3(f3), .i_csr_addr(addr),
    .i_csr_rs1_idx(idx), .i_csr_rs1_data(rs1), .i_csr_pc(pc), .i_csr_tval(tval),
    .i_csr_retire(retire), .i_csr_irq_ext(irq_e), .i_csr_irq_timer(irq_t),
    .i_csr_irq_soft(irq_s), .o_csr_rdata(rdata), .o_csr_illegal(ill_o),
    .o_csr_trap(trap_o), .o_csr_redirect(redir_o), .o_csr_redirect_pc(rpc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    valid = 0; ecall = 0; ebreak = 0; mret = 0; wen = 0; illegal = 0; retire = 0;
    irq_e = 0; irq_t = 0; irq_s = 0; f3 = 3'b000; addr = '0; idx = '0;
    rs1 = '0; pc = '0; tval = '0;
  endtask

  task automatic op(input logic [2:0] f, input logic [11:0] a, input logic [4:0] i,
                    input logic [63:0] d, input logic r);
    @(negedge clk);
    clr();
    valid = 1; wen = 1; f3 = f; addr = a; idx = i; rs1 = d; retire = r;
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic rd(input logic [11:0] a, output logic [63:0] val);
    op(3'b010, a, 5'd0, 64'd0, 1'b0);
    val = rdata;
    commit();
  endtask

  task automatic wr(input logic [2:0] f, input logic [11:0] a, input logic [4:0] i,
                    input logic [63:0] d);
    op(f, a, i, d, 1'b1);
    commit();
  endtask

  initial begin
    clr();
    // Outputs held at zero while reset is asserted.
    repeat (2) @(negedge clk);
    valid = 1; wen = 1; f3 = 3'b010; addr = 12'h300; #1;
    chk("rst_rdata", rdata, 64'd0);
    f3 = 3'b001; addr = 12'h7C0; ecall = 1; #1;
    chk("rst_illegal", {63'd0, ill_o}, 64'd0);
    chk("rst_trap", {63'd0, trap_o}, 64'd0);
    chk("rst_redirect", {63'd0, redir_o}, 64'd0);
    clr();
    @(negedge clk); rst = 0;
    repeat (10) @(posedge clk);
    #1;

    op(3'b010, 12'hB00, 5'd0, 64'd0, 1'b0);
    chk("mcycle_10", rdata, CNT ? 64'd10 : 64'd0);
    chk("idle_redirect", {63'd0, redir_o}, 64'd0);
    commit();
    rd(12'hB02, v); chk("minstret_0", v, 64'd0);
    rd(12'h301, v); chk("misa", v, 64'h8000_0000_0014_1105);
    rd(12'h300, v); chk("mstatus_rst", v, 64'h1800);

    op(3'b001, 12'h305, 5'd1, 64'h8000_0100, 1'b1);
    chk("mtvec_old", rdata, 64'd0);
    commit();
    rd(12'h305, v);  chk("mtvec_wr", v, 64'h8000_0100);
    rd(12'hB02, v);  chk("minstret_1", v, CNT ? 64'd1 : 64'd0);

    // ecall in direct mode
    @(negedge clk); clr(); valid = 1; ecall = 1; pc = 64'h2000; retire = 1; #1;
    chk("ecall_trap", {63'd0, trap_o}, 64'd1);
    chk("ecall_tgt", rpc, 64'h8000_0100);
    commit();
    rd(12'h341, v); chk("ecall_mepc", v, 64'h2000);
    rd(12'h342, v); chk("ecall_mcause", v, 64'd11);
    rd(12'h343, v); chk("ecall_mtval", v, 64'd0);
    rd(12'h300, v); chk("ecall_mstatus", v, 64'h1800);
    rd(12'hB02, v); chk("ecall_noret", v, CNT ? 64'd1 : 64'd0);

    // MODE=1x is stored as direct
    wr(3'b001, 12'h305, 5'd1, 64'h1003);
    rd(12'h305, v); chk("mtvec_mode3", v, 64'h1000);
    wr(3'b001, 12'h305, 5'd1, 64'h1001);
    wr(3'b010, 12'h304, 5'd5, 64'h80);
    wr(3'b010, 12'h300, 5'd5, 64'h8);
    rd(12'h300, v); chk("mstatus_mie", v, 64'h1808);

    // timer interrupt beats an ecall in the same cycle
    @(negedge clk); clr(); valid = 1; ecall = 1; irq_t = 1; pc = 64'h3000; retire = 1; #1;
    chk("irq_trap", {63'd0, trap_o}, 64'd1);
    chk("irq_tgt", rpc, 64'h101C);
    commit();
    rd(12'h342, v); chk("irq_mcause", v, 64'h8000_0000_0000_0007);
    rd(12'h341, v); chk("irq_mepc", v, 64'h3000);
    rd(12'h300, v); chk("irq_mstatus", v, 64'h1880);

    // mip reflects levels; global MIE=0 so no trap
    op(3'b010, 12'h344, 5'd0, 64'd0, 1'b0);
    irq_e = 1; irq_s = 1; #1;
    chk("mip_read", rdata, 64'h808);
    chk("mip_notrap", {63'd0, trap_o}, 64'd0);
    commit();

    @(negedge clk); clr(); valid = 1; mret = 1; retire = 1; #1;
    chk("mret_trap", {63'd0, trap_o}, 64'd0);
    chk("mret_redir", {63'd0, redir_o}, 64'd1);
    chk("mret_tgt", rpc, 64'h3000);
    commit();
    rd(12'h300, v); chk("mret_mstatus", v, 64'h1888);

    wr(3'b001, 12'h340, 5'd1, 64'hFF);
    op(3'b111, 12'h340, 5'h0F, 64'd0, 1'b1);
    chk("rci_old", rdata, 64'hFF);
    commit();
    rd(12'h340, v); chk("rci_new", v, 64'hF0);
    op(3'b111, 12'h340, 5'd0, 64'd0, 1'b1);
    chk("rci0_old", rdata, 64'hF0);
    commit();
    rd(12'h340, v); chk("rci0_nowr", v, 64'hF0);
    wr(3'b001, 12'h341, 5'd1, 64'h3001);
    rd(12'h341, v); chk("mepc_bit0", v, 64'h3000);

    // unknown CSR: illegal trap, vectored mode still lands on base
    @(negedge clk); clr(); valid = 1; wen = 1; f3 = 3'b001; addr = 12'h7C0; idx = 5'd1;
    rs1 = 64'h55; pc = 64'h4000; tval = 64'hDEAD_BEEF; retire = 1; #1;
    chk("ill_flag", {63'd0, ill_o}, 64'd1);
    chk("ill_trap", {63'd0, trap_o}, 64'd1);
    chk("ill_tgt", rpc, 64'h1000);
    commit();
    rd(12'h342, v); chk("ill_mcause", v, 64'd2);
    rd(12'h343, v); chk("ill_mtval", v, 64'hDEAD_BEEF);
    rd(12'h341, v); chk("ill_mepc", v, 64'h4000);
    rd(12'hB02, v); chk("ill_noret", v, CNT ? 64'd10 : 64'd0);

    @(negedge clk); clr(); valid = 1; ebreak = 1; pc = 64'h5000; tval = 64'h1234; #1;
    chk("ebrk_tgt", rpc, 64'h1000);
    commit();
    rd(12'h342, v); chk("ebrk_mcause", v, 64'd3);
    rd(12'h343, v); chk("ebrk_mtval", v, 64'h5000);

    op(3'b001, 12'h301, 5'd1, 64'd0, 1'b1);
    chk("misa_wr_ill", {63'd0, ill_o}, 64'd1);
    commit();
    rd(12'h301, v); chk("misa_kept", v, 64'h8000_0000_0014_1105);

    // counter writes override the increment; mcycle wraps
    op(3'b001, 12'hB02, 5'd1, 64'd100, 1'b1);
    chk("cnt_wr_legal", {63'd0, ill_o}, 64'd0);
    commit();
    rd(12'hB02, v); chk("minstret_wr", v, CNT ? 64'd100 : 64'd0);
    wr(3'b001, 12'hB00, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00, v); chk("mcycle_max", v, CNT ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
    rd(12'hB00, v); chk("mcycle_wrap", v, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
